// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with byte enables, 1-2 cycle registered reads and
// a post-reset clear engine that zeroes every word before any port request is accepted.

module dpr_port #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int IDX_W          = 4,
    parameter int DEPTH          = 16,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ready,
    input  logic                    cs,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   mem_word,
    input  logic                    peer_wr,
    input  logic [ADDR_WIDTH-1:0]   peer_addr,
    input  logic [DATA_WIDTH/8-1:0] peer_be,
    input  logic [DATA_WIDTH-1:0]   peer_wdata,
    output logic                    wr_en,
    output logic [IDX_W-1:0]        idx,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid
);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic                                    in_rng;
    logic                                    rd_en;
    logic [DATA_WIDTH-1:0]                   rd_word;
    logic [READ_LATENCY-1:0]                 vld_q, vld_d;
    logic [READ_LATENCY:0]                   vld_pipe;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;
    logic [READ_LATENCY:0][DATA_WIDTH-1:0]   dat_pipe;

    assign in_rng = {1'b0, addr} < DEPTH_L;
    assign idx    = addr[IDX_W-1:0];
    assign wr_en  = ready && cs && we && in_rng;
    assign rd_en  = ready && cs && !we;

    // Out-of-range reads still complete, returning zero.
    always_comb begin
        rd_word = '0;
        if (in_rng) begin
            rd_word = mem_word;
            if (COLLISION_MODE == 1 && peer_wr && peer_addr == addr) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (peer_be[b]) rd_word[8*b +: 8] = peer_wdata[8*b +: 8];
                end
            end
        end
    end

    assign vld_pipe = {vld_q, rd_en};
    assign dat_pipe = {dat_q, rd_word};
    assign rdata    = dat_pipe[READ_LATENCY];
    assign rvalid   = vld_pipe[READ_LATENCY];

    // Stages only load behind a valid, so rdata holds between completions.
    always_comb begin
        vld_d = vld_pipe[READ_LATENCY-1:0];
        dat_d = dat_q;
        for (int k = 0; k < READ_LATENCY; k++) begin
            if (vld_pipe[k]) dat_d[k] = dat_pipe[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

module dual_port_ram #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int DEPTH          = 16,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_cs,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    init_busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]           mem_q [DEPTH];
    logic                            ready;
    logic [1:0]                      cs, we, wr_en, rvalid;
    logic [1:0][BYTES-1:0]           be;
    logic [1:0][ADDR_WIDTH-1:0]      addr;
    logic [1:0][DATA_WIDTH-1:0]      wdata, rdata, mem_word;
    logic [1:0][IDX_W-1:0]           idx;

    assign cs    = {b_cs, a_cs};
    assign we    = {b_we, a_we};
    assign be    = {b_be, a_be};
    assign addr  = {b_addr, a_addr};
    assign wdata = {b_wdata, a_wdata};
    assign {b_rdata, a_rdata}   = rdata;
    assign {b_rvalid, a_rvalid} = rvalid;

    assign init_busy = (state_q == CLEAR);
    assign ready     = (state_q == READY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_d = READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port A is applied last so it owns any byte both ports enable.
    always_ff @(posedge clk) begin
        if (init_busy) mem_q[cnt_q] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[p][b]) mem_q[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int PEER = 1 - p;
        assign mem_word[p] = mem_q[idx[p]];
        dpr_port #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDR_WIDTH    (ADDR_WIDTH),
            .IDX_W         (IDX_W),
            .DEPTH         (DEPTH),
            .READ_LATENCY  (READ_LATENCY),
            .COLLISION_MODE(COLLISION_MODE)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .ready     (ready),
            .cs        (cs[p]),
            .we        (we[p]),
            .addr      (addr[p]),
            .mem_word  (mem_word[p]),
            .peer_wr   (wr_en[PEER]),
            .peer_addr (addr[PEER]),
            .peer_be   (be[PEER]),
            .peer_wdata(wdata[PEER]),
            .wr_en     (wr_en[p]),
            .idx       (idx[p]),
            .rdata     (rdata[p]),
            .rvalid    (rvalid[p])
        );
    end
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench: u_dut0 uses defaults, u_dut1 is ADDR_WIDTH=5 / READ_LATENCY=2 /
// COLLISION_MODE=1; both see the same stimulus (u_dut0 gets the low 4 address bits).
module tb_dual_port_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_cs, a_we, b_cs, b_we;
    logic [1:0]  a_be, b_be;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [15:0] a_rd0, b_rd0, a_rd1, b_rd1;
    logic        a_rv0, b_rv0, a_rv1, b_rv1, busy0, busy1;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dual_port_ram u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr[3:0]), .a_wdata(a_wdata),
        .a_rdata(a_rd0), .a_rvalid(a_rv0),
        .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr[3:0]), .b_wdata(b_wdata),
        .b_rdata(b_rd0), .b_rvalid(b_rv0),
        .init_busy(busy0)
    );

    dual_port_ram #(.ADDR_WIDTH(5), .READ_LATENCY(2), .COLLISION_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rd1), .a_rvalid(a_rv1),
        .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rd1), .b_rvalid(b_rv1),
        .init_busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_cs = 1'b0; a_we = 1'b0;
        b_cs = 1'b0; b_we = 1'b0;
    endtask

    task automatic drv_a(input logic we, input logic [1:0] be, input logic [4:0] ad, input logic [15:0] d);
        a_cs = 1'b1; a_we = we; a_be = be; a_addr = ad; a_wdata = d;
    endtask

    task automatic drv_b(input logic we, input logic [1:0] be, input logic [4:0] ad, input logic [15:0] d);
        b_cs = 1'b1; b_we = we; b_be = be; b_addr = ad; b_wdata = d;
    endtask

    // Single read on one port; latency-1 result after edge N, latency-2 after edge N+1.
    task automatic rd(input string tag, input logic pb, input logic [4:0] ad,
                      input logic [15:0] e0, input logic [15:0] e1);
        idle();
        if (pb) drv_b(1'b0, 2'b00, ad, 16'h0);
        else    drv_a(1'b0, 2'b00, ad, 16'h0);
        tick();
        idle();
        chk({tag, ".d0"}, 64'(pb ? {b_rv0, b_rd0} : {a_rv0, a_rd0}), 64'({1'b1, e0}));
        chk({tag, ".d1early"}, 64'(pb ? b_rv1 : a_rv1), 64'd0);
        tick();
        chk({tag, ".d0pulse"}, 64'(pb ? b_rv0 : a_rv0), 64'd0);
        chk({tag, ".d1"}, 64'(pb ? {b_rv1, b_rd1} : {a_rv1, a_rd1}), 64'({1'b1, e1}));
    endtask

    // Counts edges until init_busy falls; optionally pokes a write and a read mid-clear.
    task automatic wait_clear(input string tag, input bit inject);
        int n;
        bit saw_rv;
        n = 0;
        saw_rv = 1'b0;
        while (busy0 && n < 40) begin
            idle();
            if (inject && n == 4) drv_a(1'b1, 2'b11, 5'd2, 16'hFFFF);
            if (inject && n == 6) drv_b(1'b0, 2'b00, 5'd1, 16'h0);
            tick();
            n++;
            saw_rv = saw_rv | a_rv0 | b_rv0 | a_rv1 | b_rv1;
        end
        idle();
        chk({tag, ".len"}, 64'(n), 64'd16);
        chk({tag, ".busy1"}, 64'(busy1), 64'd0);
        chk({tag, ".norv"}, 64'(saw_rv), 64'd0);
    endtask

    initial begin
        idle();
        a_be = 2'b00; b_be = 2'b00; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst.busy", 64'({busy0, busy1}), 64'(2'b11));
        chk("rst.rv", 64'({a_rv0, b_rv0, a_rv1, b_rv1}), 64'd0);
        chk("rst.rd0", 64'({a_rd0, b_rd0}), 64'd0);
        chk("rst.rd1", 64'({a_rd1, b_rd1}), 64'd0);
        rst_n = 1'b1;
        wait_clear("clr0", 1'b1);

        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                drv_a(1'b0, 2'b00, 5'(i), 16'h0);
                drv_b(1'b0, 2'b00, 5'(15 - i), 16'h0);
            end else idle();
            tick();
            if (i < 16) chk("clr.d0", 64'({a_rv0, b_rv0, a_rd0 | b_rd0}), 64'({2'b11, 16'h0}));
            if (i > 0)  chk("clr.d1", 64'({a_rv1, b_rv1, a_rd1 | b_rd1}), 64'({2'b11, 16'h0}));
        end
        idle();

        drv_a(1'b1, 2'b11, 5'd3, 16'hABCD); tick(); idle();
        chk("wr.norv", 64'({a_rv0, b_rv0}), 64'd0);
        drv_b(1'b1, 2'b01, 5'd3, 16'h1234); tick(); idle();
        rd("be", 1'b0, 5'd3, 16'hAB34, 16'hAB34);

        drv_a(1'b1, 2'b11, 5'd5, 16'h1111); drv_b(1'b1, 2'b11, 5'd5, 16'h2222); tick(); idle();
        rd("wcol.full", 1'b0, 5'd5, 16'h1111, 16'h1111);
        drv_a(1'b1, 2'b01, 5'd5, 16'h1111); drv_b(1'b1, 2'b10, 5'd5, 16'h2222); tick(); idle();
        rd("wcol.split", 1'b1, 5'd5, 16'h2211, 16'h2211);
        drv_a(1'b1, 2'b00, 5'd5, 16'hFFFF); tick(); idle();
        rd("be0", 1'b0, 5'd5, 16'h2211, 16'h2211);

        drv_a(1'b1, 2'b11, 5'd7, 16'h00AA); tick(); idle();
        drv_a(1'b1, 2'b11, 5'd7, 16'h5555); drv_b(1'b0, 2'b00, 5'd7, 16'h0); tick(); idle();
        chk("rwcol.old", 64'({b_rv0, b_rd0}), 64'({1'b1, 16'h00AA}));
        tick();
        chk("rwcol.new", 64'({b_rv1, b_rd1}), 64'({1'b1, 16'h5555}));
        rd("rwcol.after", 1'b1, 5'd7, 16'h5555, 16'h5555);
        drv_b(1'b1, 2'b01, 5'd7, 16'h1234); drv_a(1'b0, 2'b00, 5'd7, 16'h0); tick(); idle();
        chk("rwcol2.old", 64'({a_rv0, a_rd0}), 64'({1'b1, 16'h5555}));
        tick();
        chk("rwcol2.merged", 64'({a_rv1, a_rd1}), 64'({1'b1, 16'h5534}));
        rd("rwcol2.after", 1'b0, 5'd7, 16'h5534, 16'h5534);

        drv_a(1'b0, 2'b00, 5'd3, 16'h0); drv_b(1'b0, 2'b00, 5'd3, 16'h0); tick(); idle();
        chk("same.d0", 64'({a_rv0, b_rv0, a_rd0, b_rd0}), 64'({2'b11, 16'hAB34, 16'hAB34}));
        tick();
        chk("same.d1", 64'({a_rv1, b_rv1, a_rd1, b_rd1}), 64'({2'b11, 16'hAB34, 16'hAB34}));

        drv_a(1'b0, 2'b00, 5'd3, 16'h0); tick(); idle();
        chk("mr.pre", 64'({a_rv0, a_rd0}), 64'({1'b1, 16'hAB34}));
        #2 rst_n = 1'b0;
        #1;
        chk("mr.async", 64'({a_rv0, a_rv1, a_rd0, a_rd1}), 64'd0);
        tick(); tick();
        chk("mr.hold", 64'({a_rv0, a_rv1, busy0}), 64'(3'b001));
        rst_n = 1'b1;
        wait_clear("clr1", 1'b0);
        rd("mr.cleared", 1'b0, 5'd3, 16'h0, 16'h0);

        for (int i = 0; i < 16; i++) begin
            drv_a(1'b1, 2'b11, 5'(i), 16'(i * 257));
            tick();
        end
        idle();
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drv_a(1'b0, 2'b00, 5'(c), 16'h0);
            else idle();
            tick();
            if (c >= 1 && c <= 16) chk("l2.stream", 64'({a_rv1, a_rd1}), 64'({1'b1, 16'((c - 1) * 257)}));
            else                   chk("l2.idle", 64'(a_rv1), 64'd0);
            if (c < 16) chk("l1.stream", 64'({a_rv0, a_rd0}), 64'({1'b1, 16'(c * 257)}));
            else        chk("l1.idle", 64'(a_rv0), 64'd0);
        end
        chk("l2.hold", 64'(a_rd1), 64'(16'h0F0F));

        rd("oor.rd", 1'b0, 5'd20, 16'h0404, 16'h0000);
        drv_a(1'b1, 2'b11, 5'd20, 16'hBEEF); tick(); idle();
        rd("oor.wr", 1'b1, 5'd20, 16'hBEEF, 16'h0000);
        rd("oor.alias", 1'b0, 5'd4, 16'hBEEF, 16'h0404);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- Parametrised true dual-port synchronous RAM. Successor to the team's single-port RAM.
- Two independent read/write ports (A, B) on one clock.
- Per-byte write enables, configurable registered read latency, and defined cross-port collision handling.
- Built-in clear engine zeroes the array after every reset. Used as shared scratch/register-file storage between processor components.

Parameters:
- DATA_WIDTH, 16, word width in bits. Must be a multiple of 8. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 4, address width of both ports.
- DEPTH, 16, number of words. Must satisfy DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request edge to rdata/rvalid. Legal values: 1 or 2.
- COLLISION_MODE, 0, same-address read vs other-port write in the same cycle. 0 = read returns old data; 1 = read returns newly written (byte-merged) data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_cs  input  1  port A request strobe.
- a_we  input  1  port A write (1) / read (0).
- a_be  input  BYTES  port A byte write enables. Bit i covers data bits [8i+7:8i].
- a_addr  input  ADDR_WIDTH  port A address.
- a_wdata  input  DATA_WIDTH  port A write data.
- a_rdata  output  DATA_WIDTH  port A read data.
- a_rvalid  output  1  one-cycle pulse; a_rdata is valid.
- b_cs, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: identical to port A.
- init_busy  output  1  clear engine active; all port requests are ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_rdata, b_rdata = 0; a_rvalid, b_rvalid = 0.
  - Read pipeline stages cleared.
  - init_busy = 1; clear counter = 0; FSM = CLEAR.
- FSM CLEAR:
  - Each cycle after rst_n rises, writes 0 to address = counter, then counter+1.
  - After writing DEPTH-1, goes to READY at the next edge; init_busy falls at that edge.
  - Clearing takes exactly DEPTH cycles.
  - Reset during CLEAR restarts from address 0.
- FSM READY: stays until reset.
- While init_busy = 1:
  - cs is ignored: no write, no rvalid.
  - Requests are not queued.
- Write (READY, cs=1, we=1):
  - At the rising edge, bytes with be[i]=1 are updated.
  - be = 0 is a legal no-op.
  - No rvalid is produced.
- Read (READY, cs=1, we=0):
  - Address sampled at edge N.
  - rdata updated and rvalid high for one cycle after edge N+READ_LATENCY-1 (i.e. visible in the cycle following edge N for latency 1).
  - Back-to-back reads every cycle are supported at full throughput on both ports.
  - rdata holds its last value when no read completes.
- Out-of-range address (addr >= DEPTH):
  - Write is ignored.
  - Read returns 0 with rvalid=1.
- Both ports write the same address in the same cycle: per byte, port A wins where both be bits are set; otherwise each port's enabled bytes are applied.
- One port reads while the other writes the same address in the same cycle:
  - COLLISION_MODE=0: the read returns pre-write contents.
  - COLLISION_MODE=1: the read returns the post-write merged word.
- Both ports reading the same address: both return identical data.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset). Array contents are rewritten to 0 by CLEAR.

Test Plan (default parameters unless stated):
- Reset release: rst_n low 3 cycles then high → init_busy=1 for exactly 16 cycles, then 0. Reads of addr 0..15 on both ports return 0x0000. A write attempted at cycle 5 of clear has no effect.
- Byte enables: A writes addr 3 = 0xABCD be=11; next cycle B writes addr 3 = 0x1234 be=01; then A reads addr 3 → a_rdata=0xAB34 with a_rvalid pulse one cycle after the request edge.
- Write collision at addr 5:
  - A=0x1111 be=11 and B=0x2222 be=11 in the same cycle → read 0x1111.
  - A=0x1111 be=01 and B=0x2222 be=10 in the same cycle → read 0x2211.
- Read/write collision: addr 7 holds 0x00AA; A writes 0x5555 while B reads addr 7 in the same cycle → b_rdata=0x00AA (COLLISION_MODE=0), 0x5555 (COLLISION_MODE=1). A later read returns 0x5555 in both modes.
- READ_LATENCY=2: write addr 0..15 = addr*0x0101; stream reads on A of addr 0..15 on consecutive cycles → rvalid high 16 consecutive cycles starting 2 edges after the first request; data in order 0x0000..0x0F0F. Addr 20 with ADDR_WIDTH=5, DEPTH=16 → 0x0000 with rvalid.
- Reset mid-read: issue a read of addr 3 (holding 0xAB34) and drop rst_n before rvalid → rdata=0 and rvalid=0 immediately, no rvalid after release. Clear reruns for 16 cycles; addr 3 then reads 0x0000.
